// File: rtl/multi_lane_fifo_if.sv
// Handshake bundle between a multi-lane FIFO and its producer/consumer.
// The master side drives push/poll requests, and the slave side is the FIFO.
interface multi_lane_fifo_if #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MULTI_PUSH = 2,
    parameter int MULTI_POP  = 4
);
    localparam int PW = $clog2(MULTI_PUSH) + 1;
    localparam int RW = $clog2(MULTI_POP) + 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                                  flush;
    logic [PW-1:0]                         push_cnt;
    logic [MULTI_PUSH-1:0][DATA_WIDTH-1:0] data_in;
    logic [PW-1:0]                         space_cnt;
    logic [RW-1:0]                         poll_cnt;
    logic [MULTI_POP-1:0][DATA_WIDTH-1:0]  data_out;
    logic [RW-1:0]                         ready_cnt;
    logic [CW-1:0]                         count;
    logic                                  full;
    logic                                  empty;
    logic                                  overflow;
    logic                                  underflow;

    modport master (
        output flush, push_cnt, data_in, poll_cnt,
        input  space_cnt, data_out, ready_cnt, count, full, empty, overflow, underflow
    );

    modport slave (
        input  flush, push_cnt, data_in, poll_cnt,
        output space_cnt, data_out, ready_cnt, count, full, empty, overflow, underflow
    );
endinterface

// File: rtl/multi_lane_fifo.sv
// Same-clock FIFO accepting up to MULTI_PUSH writes and MULTI_POP reads per cycle.
// Accepted counts saturate against registered space and data, so there is no stall path.
module multi_lane_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MULTI_PUSH = 2,
    parameter int MULTI_POP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    multi_lane_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(MULTI_PUSH) + 1;
    localparam int RW = $clog2(MULTI_POP) + 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]         w_ptr_q, w_ptr_d;
    logic [AW-1:0]         r_ptr_q, r_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]         free_slots;
    logic [PW-1:0]         space_cnt;
    logic [PW-1:0]         acc_push;
    logic [RW-1:0]         ready_cnt;
    logic [RW-1:0]         acc_pop;
    logic [CW:0]           count_sum;
    logic                  count_sum_unused;

    logic [MULTI_PUSH-1:0] wr_en;
    logic [AW-1:0]         wr_addr [MULTI_PUSH];
    logic [MULTI_POP-1:0][DATA_WIDTH-1:0] data_out;

    // Space and data come only from registered occupancy. A same-cycle pop never frees push space.
    always_comb begin
        free_slots = CW'(DEPTH) - count_q;
        space_cnt  = (free_slots >= CW'(MULTI_PUSH)) ? PW'(MULTI_PUSH) : free_slots[PW-1:0];
        ready_cnt  = (count_q >= CW'(MULTI_POP)) ? RW'(MULTI_POP) : count_q[RW-1:0];
        acc_push   = (bus.push_cnt < space_cnt) ? bus.push_cnt : space_cnt;
        acc_pop    = (bus.poll_cnt < ready_cnt) ? bus.poll_cnt : ready_cnt;
    end

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        count_sum   = {1'b0, count_q} + (CW+1)'(acc_push) - (CW+1)'(acc_pop);
        if (bus.flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            w_ptr_d     = w_ptr_q + AW'(acc_push);
            r_ptr_d     = r_ptr_q + AW'(acc_pop);
            count_d     = count_sum[CW-1:0];
            overflow_d  = (bus.push_cnt > space_cnt);
            underflow_d = (bus.poll_cnt > ready_cnt);
        end
    end

    // The sum never exceeds DEPTH, so its extra carry bit is intentionally unused.
    assign count_sum_unused = count_sum[CW];

    always_comb begin
        for (int i = 0; i < MULTI_PUSH; i++) begin
            wr_en[i]   = !bus.flush && (acc_push > PW'(i));
            wr_addr[i] = w_ptr_q + AW'(i);
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage has no reset. Pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MULTI_PUSH; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_addr[i]] <= bus.data_in[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < MULTI_POP; i++) begin
            data_out[i] = (ready_cnt > RW'(i)) ? mem_q[r_ptr_q + AW'(i)] : '0;
        end
    end

    assign bus.data_out  = data_out;
    assign bus.space_cnt = space_cnt;
    assign bus.ready_cnt = ready_cnt;
    assign bus.count     = count_q;
    assign bus.full      = (count_q == CW'(DEPTH));
    assign bus.empty     = (count_q == '0);
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_multi_lane_fifo.sv
// Self-checking bench for multi_lane_fifo: directed plan steps plus random traffic
// compared against a queue-based reference model.
module tb_multi_lane_fifo;
    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int MPUSH = 2;
    localparam int MPOP  = 4;
    localparam int PW    = $clog2(MPUSH) + 1;
    localparam int RW    = $clog2(MPOP) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_lane_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .MULTI_PUSH(MPUSH), .MULTI_POP(MPOP)) bus ();

    multi_lane_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .MULTI_PUSH(MPUSH), .MULTI_POP(MPOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [DW-1:0] q [$];
    bit          exp_ov = 1'b0;
    bit          exp_un = 1'b0;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        int sz;
        sz = q.size();
        check({tag, ".count"}, 64'(bus.count), 64'(sz));
        check({tag, ".empty"}, 64'(bus.empty), 64'(sz == 0));
        check({tag, ".full"}, 64'(bus.full), 64'(sz == DEPTH));
        check({tag, ".space"}, 64'(bus.space_cnt), 64'(imin(DEPTH - sz, MPUSH)));
        check({tag, ".ready"}, 64'(bus.ready_cnt), 64'(imin(sz, MPOP)));
        check({tag, ".ovf"}, 64'(bus.overflow), 64'(exp_ov));
        check({tag, ".unf"}, 64'(bus.underflow), 64'(exp_un));
        for (int i = 0; i < MPOP; i++) begin
            check($sformatf("%s.lane%0d", tag, i), 64'(bus.data_out[i]),
                  (i < sz) ? 64'(q[i]) : 64'd0);
        end
    endtask

    task automatic drive(int push, int poll, bit fl, logic [DW-1:0] d0, logic [DW-1:0] d1);
        bus.push_cnt   = PW'(push);
        bus.poll_cnt   = RW'(poll);
        bus.flush      = fl;
        bus.data_in[0] = d0;
        bus.data_in[1] = d1;
    endtask

    // Advance one clock edge, update the model from the rules, then compare everything.
    task automatic cycle(string tag);
        int sz, space, ready, push, poll, ap, ao;
        bit fl;
        logic [DW-1:0] din [MPUSH];
        sz    = q.size();
        space = imin(DEPTH - sz, MPUSH);
        ready = imin(sz, MPOP);
        push  = int'(bus.push_cnt);
        poll  = int'(bus.poll_cnt);
        fl    = bus.flush;
        for (int i = 0; i < MPUSH; i++) din[i] = bus.data_in[i];
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            exp_ov = 1'b0;
            exp_un = 1'b0;
        end else begin
            exp_ov = (push > space);
            exp_un = (poll > ready);
            ap = imin(push, space);
            ao = imin(poll, ready);
            for (int i = 0; i < ao; i++) void'(q.pop_front());
            for (int i = 0; i < ap; i++) q.push_back(din[i]);
        end
        check_all(tag);
    endtask

    initial begin
        drive(0, 0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        check_all("reset");
        check("reset.space2", 64'(bus.space_cnt), 64'd2);
        cycle("idle");

        // Fill with 1..16, two lanes per cycle.
        for (int c = 0; c < 8; c++) begin
            drive(2, 0, 1'b0, DW'(2*c + 1), DW'(2*c + 2));
            cycle("fill");
        end
        check("fill.count16", 64'(bus.count), 64'd16);
        check("fill.full", 64'(bus.full), 64'd1);
        check("fill.space0", 64'(bus.space_cnt), 64'd0);

        // Drain four at a time. Each group must present consecutive values.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < MPOP; i++)
                check($sformatf("drain%0d.lane%0d", k, i), 64'(bus.data_out[i]), 64'(4*k + i + 1));
            drive(0, 4, 1'b0, '0, '0);
            cycle("drain");
        end
        check("drain.empty", 64'(bus.empty), 64'd1);

        // Move both pointers to 14, then write across the wrap point.
        for (int c = 0; c < 7; c++) begin
            drive(2, 0, 1'b0, DW'(200 + c), DW'(300 + c));
            cycle("adv_w");
        end
        drive(0, 4, 1'b0, '0, '0); cycle("adv_r");
        drive(0, 4, 1'b0, '0, '0); cycle("adv_r");
        drive(0, 4, 1'b0, '0, '0); cycle("adv_r");
        drive(0, 2, 1'b0, '0, '0); cycle("adv_r");
        drive(2, 0, 1'b0, 32'hA, 32'hB); cycle("wrap_w");
        drive(2, 0, 1'b0, 32'hC, 32'hD); cycle("wrap_w");
        drive(0, 0, 1'b0, '0, '0);
        check("wrap.ready4", 64'(bus.ready_cnt), 64'd4);
        check("wrap.lane0", 64'(bus.data_out[0]), 64'hA);
        check("wrap.lane1", 64'(bus.data_out[1]), 64'hB);
        check("wrap.lane2", 64'(bus.data_out[2]), 64'hC);
        check("wrap.lane3", 64'(bus.data_out[3]), 64'hD);
        drive(0, 4, 1'b0, '0, '0); cycle("wrap_r");

        // Saturation at count 15: only one lane fits, and four entries leave.
        for (int c = 0; c < 7; c++) begin
            drive(2, 0, 1'b0, DW'(100 + 2*c), DW'(101 + 2*c));
            cycle("sat_fill");
        end
        drive(1, 0, 1'b0, DW'(114), '0); cycle("sat_fill");
        drive(2, 4, 1'b0, 32'h55, 32'h66); cycle("sat");
        check("sat.count12", 64'(bus.count), 64'd12);
        check("sat.ovf_pulse", 64'(bus.overflow), 64'd1);
        drive(0, 0, 1'b0, '0, '0); cycle("sat_idle");
        check("sat.ovf_clear", 64'(bus.overflow), 64'd0);
        drive(0, 4, 1'b0, '0, '0); cycle("sat_drain");
        drive(0, 4, 1'b0, '0, '0); cycle("sat_drain");
        check("sat.last55", 64'(bus.data_out[3]), 64'h55);
        drive(0, 4, 1'b0, '0, '0); cycle("sat_drain");

        // Underflow: one entry present, three requested.
        drive(1, 0, 1'b0, 32'h77, '0); cycle("unf_fill");
        drive(0, 3, 1'b0, '0, '0); cycle("unf");
        check("unf.count0", 64'(bus.count), 64'd0);
        check("unf.pulse", 64'(bus.underflow), 64'd1);
        drive(0, 0, 1'b0, '0, '0); cycle("unf_idle");
        check("unf.clear", 64'(bus.underflow), 64'd0);

        // Random traffic with occasional flush and over-requests.
        for (int n = 0; n < 400; n++) begin
            drive(int'($urandom_range(0, MPUSH)), int'($urandom_range(0, MPOP + 1)),
                  ($urandom_range(0, 15) == 0), DW'($urandom), DW'($urandom));
            cycle("rand");
        end
        drive(1'b0, 0, 1'b1, '0, '0); cycle("rand_flush");

        // Flush at count 9 with a push pending.
        for (int c = 0; c < 4; c++) begin
            drive(2, 0, 1'b0, DW'(500 + c), DW'(600 + c));
            cycle("fl_fill");
        end
        drive(1, 0, 1'b0, DW'(700), '0); cycle("fl_fill");
        drive(2, 0, 1'b1, 32'hDEAD, 32'hBEEF); cycle("flush");
        check("flush.count0", 64'(bus.count), 64'd0);
        check("flush.no_ovf", 64'(bus.overflow), 64'd0);
        drive(0, 0, 1'b0, '0, '0); cycle("flush_idle");

        // A flush at full with an excess push must not raise overflow.
        for (int c = 0; c < 8; c++) begin
            drive(2, 0, 1'b0, DW'(c), DW'(c + 50));
            cycle("flf_fill");
        end
        drive(2, 0, 1'b1, 32'h1, 32'h2); cycle("flush_full");
        check("flush_full.no_ovf", 64'(bus.overflow), 64'd0);

        // Asynchronous reset between edges with count 5.
        drive(2, 0, 1'b0, 32'h11, 32'h12); cycle("ar_fill");
        drive(2, 0, 1'b0, 32'h13, 32'h14); cycle("ar_fill");
        drive(1, 0, 1'b0, 32'h15, '0);     cycle("ar_fill");
        drive(2, 0, 1'b0, 32'h16, 32'h17);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("areset.empty", 64'(bus.empty), 64'd1);
        check("areset.count0", 64'(bus.count), 64'd0);
        q.delete();
        exp_ov = 1'b0;
        exp_un = 1'b0;
        check_all("areset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 1'b0, '0, '0);
        check_all("post_reset");
        cycle("post_reset_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
